// File: rtl/seq_alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_SRL   = 4'd4;
    localparam logic [3:0] OP_SRA   = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_SLL   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MULTU = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;
    localparam logic [3:0] OP_LAST  = 4'd11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // True for the opcodes handled by the iterative multiply/divide engine.
    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring) engine.
// One step per cycle for WIDTH cycles. hi/lo expose the result of the step
// being taken this cycle, so on the cycle done is high they carry the final
// product/remainder/quotient and the top can register them on that edge.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    localparam int CW = SHW + 1;

    logic             running;
    logic             is_div;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mq_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] mq_n;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    // One iteration step: acc is the product high half or running remainder,
    // mq is the multiplier being consumed or the quotient being built.
    // A set top bit in div_diff means the trial subtract borrowed.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_q, mq_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        acc_n     = mul_sum[WIDTH:1];
        mq_n      = {mul_sum[0], mq_q[WIDTH-1:1]};
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                acc_n = div_diff[WIDTH-1:0];
                mq_n  = {mq_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = div_shift[WIDTH-1:0];
                mq_n  = {mq_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Load operands on start, then step until the counter runs out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            is_div  <= 1'b0;
            cnt     <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            b_q     <= '0;
        end else if (start) begin
            running <= 1'b1;
            is_div  <= (op == OP_DIVU);
            cnt     <= CW'(WIDTH);
            acc_q   <= '0;
            mq_q    <= a;
            b_q     <= b;
        end else if (running) begin
            acc_q <= acc_n;
            mq_q  <= mq_n;
            cnt   <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                running <= 1'b0;
            end
        end
    end

    assign done = running && (cnt == CW'(1));
    assign hi   = acc_n;
    assign lo   = mq_n;
    assign dz   = is_div && (b_q == '0);

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake. Single-cycle ops are computed
// at accept; MULTU/DIVU are handed to the iterative engine.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             err
);

    logic [1:0]       state;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_lo;
    logic             sc_err;
    logic             accept;
    logic             md_start;
    logic             md_done;
    logic             md_dz;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_ready && in_valid;
    assign md_start  = accept && is_iterative(op);
    assign shamt     = b[SHW-1:0];

    // Single-cycle datapath; anything above OP_LAST is flagged illegal.
    always_comb begin
        sc_lo  = '0;
        sc_err = 1'b0;
        case (op)
            OP_ADD:   sc_lo = a + b;
            OP_SUB:   sc_lo = a - b;
            OP_AND:   sc_lo = a & b;
            OP_OR:    sc_lo = a | b;
            OP_SRL:   sc_lo = a >> shamt;
            OP_SRA:   sc_lo = $signed(a) >>> shamt;
            OP_XOR:   sc_lo = a ^ b;
            OP_SLL:   sc_lo = a << shamt;
            OP_SLT:   sc_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  sc_lo = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MULTU: sc_lo = '0;
            OP_DIVU:  sc_lo = '0;
            default:  sc_err = 1'b1;
        endcase
    end

    seq_alu_muldiv #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .op    (op),
        .a     (a),
        .b     (b),
        .done  (md_done),
        .hi    (md_hi),
        .lo    (md_lo),
        .dz    (md_dz)
    );

    // Control FSM and output registers; results read as zero unless valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            res_lo <= '0;
            res_hi <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (is_iterative(op)) begin
                            state <= S_BUSY;
                        end else begin
                            state  <= S_DONE;
                            res_lo <= sc_lo;
                            res_hi <= '0;
                            err    <= sc_err;
                        end
                    end
                end
                S_BUSY: begin
                    if (md_done) begin
                        state  <= S_DONE;
                        res_lo <= md_lo;
                        res_hi <= md_hi;
                        err    <= md_dz;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state  <= S_IDLE;
                        res_lo <= '0;
                        res_hi <= '0;
                        err    <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
